txepad: RTL and testbench
=========================

TXEPAD -- requirements
Module: txepad

Interface
REQ-001 Parameter MINNIBBLES, default 120, minimum transmitted nibbles per frame, excluding CRC.
REQ-002 Parameter LGNCOUNT (derived, not overridable): 7 when MINNIBBLES<127, 8 when <255, else 9.
REQ-003 i_clk  input  1  system clock; the only clock.
REQ-004 i_reset  input  1  reset, synchronous, active-high.
REQ-005 i_ce  input  1  nibble strobe; all state and outputs advance only when i_ce=1, except reset.
REQ-006 i_en  input  1  padding enable; sampled at frame start only.
REQ-007 i_cancel  input  1  abort the current frame.
REQ-008 i_v  input  1  input nibble valid; frame = contiguous i_v=1 run.
REQ-009 i_d  input  4  input data nibble.
REQ-010 o_v  output  1  output nibble valid.
REQ-011 o_d  output  4  output data nibble.
REQ-012 o_busy  output  1  block is padding or holding a gap; upstream shall not start a frame.
REQ-013 o_err  output  1  one-i_ce pulse: i_v seen while o_busy=1.

Function
REQ-014 Registered datapath: o_v/o_d equal the previous i_ce's i_v/i_d in PASS; latency exactly one i_ce cycle.
REQ-015 States: IDLE, PASS, PAD, GAP (GAP only per REQ-027).
REQ-016 IDLE: i_v=1 -> PASS; count loads 1; o_v=1, o_d=i_d; en_r latches i_en.
REQ-017 PASS: i_v=1 -> forward nibble; count increments, saturating at MINNIBBLES.
REQ-018 PASS: i_v=0 with en_r=1 and count<MINNIBBLES -> PAD; o_v=1, o_d=4'h0; count increments.
REQ-019 PASS: i_v=0 otherwise -> o_v=0; next state GAP if enabled, else IDLE.
REQ-020 PAD: emits o_v=1, o_d=4'h0 each i_ce until count reaches MINNIBBLES; the nibble making count==MINNIBBLES is the last pad nibble; then o_v=0, next state GAP or IDLE.
REQ-021 Total o_v=1 nibbles per frame = max(input length, MINNIBBLES) when en_r=1; = input length when en_r=0.
REQ-022 o_busy=1 in PAD and GAP; 0 in IDLE and PASS.
REQ-023 i_v=1 in PAD or GAP: input nibble dropped, o_err=1 for that i_ce, state unaffected.
REQ-024 i_cancel=1 (any state, on i_ce): o_v=0, o_d=0, count=0, state IDLE next; cancel wins over simultaneous i_v; no GAP follows a cancel.
REQ-025 i_ce=0: all registers hold; o_err holds its value.
REQ-026 Count never wraps; width LGNCOUNT bits.

Configuration
REQ-027 Macro TXEPAD_GAP_EN defined: after every non-cancelled frame end, state GAP for exactly 24 i_ce cycles (96-bit inter-frame gap), o_busy=1, o_v=0, then IDLE. Not defined: GAP state absent; frame end goes straight to IDLE and o_busy=1 only in PAD.

Reset
REQ-028 i_reset=1 on any i_clk edge, regardless of i_ce: state IDLE, count=0, en_r=0, gap counter=0, o_v=0, o_d=0, o_busy=0, o_err=0.
REQ-029 Reset mid-PAD or mid-GAP abandons the frame; no further pad nibbles emitted.

Verification
REQ-030 i_en=1, 40-nibble frame, i_ce always 1 -> 40 data nibbles then 80 zero nibbles, o_v high 120 consecutive cycles, o_busy high during 80 pad cycles.
REQ-031 i_en=1, 150-nibble frame -> 150 nibbles out unchanged, no padding, o_busy stays 0 (without TXEPAD_GAP_EN).
REQ-032 i_en=0, 10-nibble frame -> exactly 10 nibbles out, one-cycle latency, no padding.
REQ-033 i_cancel at nibble 30 of a 40-nibble padded frame -> o_v=0 next cycle, IDLE, o_busy=0, new frame accepted on following i_ce.
REQ-034 i_v=1 asserted at pad nibble 5 -> o_err single-cycle pulse, padding continues to 120 total, input dropped.
REQ-035 TXEPAD_GAP_EN, i_ce every 4th clock, 120-nibble frame -> o_busy high exactly 24 i_ce strobes after last nibble; i_reset pulsed mid-gap -> all outputs 0 next clock.

Source files
------------

// File: rtl/txepad.sv
// Frame pad stage for a nibble stream: forwards frames one i_ce late and zero-pads short frames.
// Optional TXEPAD_GAP_EN adds a 24-nibble inter-frame gap after every completed frame.
module txepad #(
  parameter int unsigned MINNIBBLES = 120
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_cancel,
  input  logic       i_v,
  input  logic [3:0] i_d,
  output logic       o_v,
  output logic [3:0] o_d,
  output logic       o_busy,
  output logic       o_err
);

  localparam int unsigned LGNCOUNT = (MINNIBBLES < 127) ? 7 : ((MINNIBBLES < 255) ? 8 : 9);
  localparam logic [LGNCOUNT-1:0] MinCnt = LGNCOUNT'(MINNIBBLES);

`ifdef TXEPAD_GAP_EN
  localparam logic [4:0] GapLast = 5'd23;
  typedef enum logic [1:0] {StIdle, StPass, StPad, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPass, StPad} state_e;
`endif

  state_e              state_q, state_d;
  logic [LGNCOUNT-1:0] count_q, count_d;
  logic                en_q, en_d;
  logic                v_q, v_d;
  logic [3:0]          d_q, d_d;
  logic                err_q, err_d;
`ifdef TXEPAD_GAP_EN
  logic [4:0]          gap_q, gap_d;
`endif

  // Where a frame goes once its last nibble (data or pad) has been emitted.
  state_e end_state;
`ifdef TXEPAD_GAP_EN
  assign end_state = StGap;
`else
  assign end_state = StIdle;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    en_d    = en_q;
    v_d     = 1'b0;
    d_d     = 4'h0;
    err_d   = 1'b0;
`ifdef TXEPAD_GAP_EN
    gap_d   = 5'd0;
`endif
    if (i_cancel) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_v) begin
            state_d = StPass;
            count_d = LGNCOUNT'(1);
            en_d    = i_en;
            v_d     = 1'b1;
            d_d     = i_d;
          end
        end
        StPass: begin
          if (i_v) begin
            v_d = 1'b1;
            d_d = i_d;
            if (count_q < MinCnt) count_d = count_q + 1'b1;
          end else if (en_q && (count_q < MinCnt)) begin
            state_d = StPad;
            v_d     = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            state_d = end_state;
          end
        end
        StPad: begin
          // Input nibbles arriving here are dropped and flagged.
          err_d = i_v;
          if (count_q < MinCnt) begin
            v_d     = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            state_d = end_state;
          end
        end
`ifdef TXEPAD_GAP_EN
        StGap: begin
          err_d = i_v;
          if (gap_q == GapLast) begin
            state_d = StIdle;
          end else begin
            gap_d = gap_q + 5'd1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      count_q <= '0;
      en_q    <= 1'b0;
      v_q     <= 1'b0;
      d_q     <= 4'h0;
      err_q   <= 1'b0;
`ifdef TXEPAD_GAP_EN
      gap_q   <= 5'd0;
`endif
    end else if (i_ce) begin
      state_q <= state_d;
      count_q <= count_d;
      en_q    <= en_d;
      v_q     <= v_d;
      d_q     <= d_d;
      err_q   <= err_d;
`ifdef TXEPAD_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign o_v   = v_q;
  assign o_d   = d_q;
  assign o_err = err_q;
`ifdef TXEPAD_GAP_EN
  assign o_busy = (state_q == StPad) || (state_q == StGap);
`else
  assign o_busy = (state_q == StPad);
`endif

  // Sanity properties on the frame counter and the pad stream.
  a_count_bound : assert property (@(posedge i_clk) disable iff (i_reset) count_q <= MinCnt);
  a_pad_zero : assert property (@(posedge i_clk) disable iff (i_reset)
    (o_v && o_busy) |-> (o_d == 4'h0));

endmodule

// File: tb/tb_txepad.sv
// Directed bench for txepad: pass-through, padding, cancel, error pulse, reset and optional gap.
// Gap-dependent expectations follow the TXEPAD_GAP_EN build macro.
module tb_txepad;

  logic       i_clk = 1'b0;
  logic       i_reset, i_ce, i_en, i_cancel, i_v;
  logic [3:0] i_d;
  logic       o_v, o_busy, o_err;
  logic [3:0] o_d;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_gap   = 0;

`ifdef TXEPAD_GAP_EN
  localparam int GapCyc = 24;
`else
  localparam int GapCyc = 0;
`endif

  txepad dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_en    (i_en),
    .i_cancel(i_cancel),
    .i_v     (i_v),
    .i_d     (i_d),
    .o_v     (o_v),
    .o_d     (o_d),
    .o_busy  (o_busy),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One i_ce strobe, preceded by ce_gap idle clocks; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [3:0] d);
    i_v = v;
    i_d = d;
    repeat (ce_gap) begin
      i_ce = 1'b0;
      @(posedge i_clk);
      #1;
    end
    i_ce = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  // Called right after the frame-ending strobe; counts strobes spent busy.
  task automatic drain_gap(input string tag);
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 40) begin
      n++;
      cyc(1'b0, 4'h0);
    end
    check_eq(tag, n, GapCyc);
  endtask

  task automatic send_frame(input int len, input logic en, output int bad);
    logic [3:0] d;
    bad = 0;
    i_en = en;
    for (int k = 0; k < len; k++) begin
      d = 4'(k * 7 + 3);
      cyc(1'b1, d);
      if (k == 0) i_en = ~en;  // en is latched at frame start only
      if (o_v !== 1'b1 || o_d !== d || o_busy !== 1'b0) bad++;
    end
  endtask

  initial begin
    int bad, np, ne, nv;
    i_reset  = 1'b1;
    i_ce     = 1'b0;
    i_en     = 1'b0;
    i_cancel = 1'b0;
    i_v      = 1'b1;
    i_d      = 4'h5;
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("reset_v", o_v, 0);
    check_eq("reset_d", o_d, 0);
    check_eq("reset_busy", o_busy, 0);
    check_eq("reset_err", o_err, 0);
    i_reset = 1'b0;
    cyc(1'b0, 4'h0);
    check_eq("idle_v", o_v, 0);

    // Unpadded 10-nibble frame, with an i_ce stall mid-frame.
    bad = 0;
    i_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 4'(k + 3));
      if (o_v !== 1'b1 || o_d !== 4'(k + 3) || o_busy !== 1'b0) bad++;
      if (k == 4) begin
        i_ce = 1'b0;
        i_v  = 1'b1;
        i_d  = 4'hF;
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("ce_hold_d", o_d, 7);
      end
    end
    check_eq("nopad_data", bad, 0);
    cyc(1'b0, 4'h0);
    check_eq("nopad_end_v", o_v, 0);
    drain_gap("nopad_gap");
    nv = 0;
    repeat (5) begin
      cyc(1'b0, 4'h0);
      if (o_v !== 1'b0) nv++;
    end
    check_eq("nopad_quiet", nv, 0);

    // 40-nibble padded frame: 80 zero nibbles with o_busy.
    send_frame(40, 1'b1, bad);
    check_eq("pad40_data", bad, 0);
    np = 0;
    repeat (80) begin
      cyc(1'b0, 4'h0);
      if (o_v === 1'b1 && o_d === 4'h0 && o_busy === 1'b1) np++;
    end
    check_eq("pad40_count", np, 80);
    cyc(1'b0, 4'h0);
    check_eq("pad40_end_v", o_v, 0);
    drain_gap("pad40_gap");

    // 150-nibble frame: no padding, never busy while passing.
    send_frame(150, 1'b1, bad);
    check_eq("long_data", bad, 0);
    cyc(1'b0, 4'h0);
    check_eq("long_end_v", o_v, 0);
    drain_gap("long_gap");

    // Cancel at nibble 30, then an immediate new frame.
    send_frame(30, 1'b1, bad);
    check_eq("cancel_pre_data", bad, 0);
    i_cancel = 1'b1;
    cyc(1'b1, 4'hF);
    check_eq("cancel_v", o_v, 0);
    check_eq("cancel_d", o_d, 0);
    check_eq("cancel_busy", o_busy, 0);
    i_cancel = 1'b0;
    i_en = 1'b0;
    cyc(1'b1, 4'hA);
    check_eq("restart_v", o_v, 1);
    check_eq("restart_d", o_d, 10);
    cyc(1'b0, 4'h0);
    check_eq("restart_end_v", o_v, 0);
    drain_gap("restart_gap");

    // Input during pad nibble 5: single o_err pulse, held across an i_ce stall.
    send_frame(40, 1'b1, bad);
    check_eq("err_frame_data", bad, 0);
    np = 0;
    ne = 0;
    for (int k = 0; k < 80; k++) begin
      cyc(k == 4, (k == 4) ? 4'hF : 4'h0);
      if (o_v === 1'b1 && o_d === 4'h0) np++;
      if (o_err === 1'b1) ne++;
      if (k == 4) begin
        check_eq("err_pulse", o_err, 1);
        i_ce = 1'b0;
        i_v  = 1'b0;
        @(posedge i_clk);
        #1;
        check_eq("err_hold", o_err, 1);
        check_eq("err_hold_v", o_v, 1);
      end
    end
    check_eq("err_pad_count", np, 80);
    check_eq("err_pulse_count", ne, 1);
    cyc(1'b0, 4'h0);
    check_eq("err_end_v", o_v, 0);
    drain_gap("err_gap");

    // Cancel mid-pad: no gap, no further pad nibbles.
    send_frame(20, 1'b1, bad);
    repeat (10) cyc(1'b0, 4'h0);
    check_eq("padc_busy_pre", o_busy, 1);
    i_cancel = 1'b1;
    cyc(1'b0, 4'h0);
    i_cancel = 1'b0;
    check_eq("padc_v", o_v, 0);
    check_eq("padc_busy", o_busy, 0);
    nv = 0;
    repeat (3) begin
      cyc(1'b0, 4'h0);
      if (o_v !== 1'b0 || o_busy !== 1'b0) nv++;
    end
    check_eq("padc_quiet", nv, 0);

    // Reset mid-pad with i_ce low.
    send_frame(20, 1'b1, bad);
    repeat (5) cyc(1'b0, 4'h0);
    i_reset = 1'b1;
    i_ce = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check_eq("rstpad_v", o_v, 0);
    check_eq("rstpad_busy", o_busy, 0);
    nv = 0;
    repeat (5) begin
      cyc(1'b0, 4'h0);
      if (o_v !== 1'b0 || o_busy !== 1'b0) nv++;
    end
    check_eq("rstpad_quiet", nv, 0);

`ifdef TXEPAD_GAP_EN
    // Slow strobe: gap lasts 24 strobes; input in gap flags o_err; reset clears mid-gap.
    ce_gap = 3;
    send_frame(120, 1'b0, bad);
    check_eq("gap_frame_data", bad, 0);
    cyc(1'b0, 4'h0);
    check_eq("gap_end_busy", o_busy, 1);
    drain_gap("gap_len");
    send_frame(5, 1'b0, bad);
    cyc(1'b0, 4'h0);
    repeat (5) cyc(1'b0, 4'h0);
    cyc(1'b1, 4'h9);
    check_eq("gap_err", o_err, 1);
    check_eq("gap_err_v", o_v, 0);
    repeat (3) cyc(1'b0, 4'h0);
    check_eq("gap_mid_busy", o_busy, 1);
    i_reset = 1'b1;
    i_ce = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check_eq("gaprst_busy", o_busy, 0);
    check_eq("gaprst_v", o_v, 0);
    check_eq("gaprst_err", o_err, 0);
    ce_gap = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
